emblem_sequencer: RTL and testbench

//  Frame-synchronous show sequencer for the shield emblem overlay. On a trigger, or

---
 rtl/emblem_sequencer.sv | 182 ++++++++++++++++++
 tb/tb_emblem_sequencer.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/emblem_sequencer.sv
// emblem_sequencer: frame-synchronous slide-in / hold / blink / slide-out sequencer
// for the emblem overlay. Defining EMBLEM_BOUNCE_EN adds a horizontal bounce during HOLD.
module emblem_sequencer #(
    parameter int SLIDE_DIST   = 160,
    parameter int SLIDE_STEP   = 4,
    parameter int HOLD_FRAMES  = 120,
    parameter int BLINK_FRAMES = 32,
    parameter int BLINK_PERIOD = 8,
    parameter int AUTO_GAP     = 60
`ifdef EMBLEM_BOUNCE_EN
    ,
    parameter int BOUNCE_MAX   = 16
`endif
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       frame_start_i,
    input  logic       trigger_i,
    input  logic       abort_i,
    input  logic       auto_mode_i,
    output logic       emblem_en_o,
    output logic [9:0] y_off_o,
    output logic [7:0] x_off_o,
    output logic       invert_o,
    output logic       busy_o,
    output logic [2:0] state_o
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ENTER = 3'd1,
        HOLD  = 3'd2,
        BLINK = 3'd3,
        EXIT  = 3'd4
    } state_t;

    state_t      state_q;
    logic        emblem_en_q;
    logic        invert_q;
    logic        busy_q;
    logic        pending_q;
    logic [9:0]  y_off_q;
    logic [7:0]  cnt_q;
    logic [7:0]  gap_q;

    logic [9:0]  y_dn_d;
    logic [10:0] y_sum_d;
    logic [9:0]  y_up_d;
    logic [7:0]  cnt_inc_d;
    logic        blink_tgl_d;
    logic        start_d;
    logic        clear_d;

    // Saturating slide arithmetic; the 11-bit sum keeps the upward slide from wrapping.
    assign y_dn_d      = (y_off_q > 10'(SLIDE_STEP)) ? (y_off_q - 10'(SLIDE_STEP)) : 10'd0;
    assign y_sum_d     = {1'b0, y_off_q} + 11'(SLIDE_STEP);
    assign y_up_d      = (y_sum_d >= 11'(SLIDE_DIST)) ? 10'(SLIDE_DIST) : y_sum_d[9:0];
    assign cnt_inc_d   = cnt_q + 8'd1;
    assign blink_tgl_d = ((cnt_inc_d % 8'(BLINK_PERIOD)) == 8'd0);
    assign start_d     = pending_q | trigger_i | (auto_mode_i & (gap_q == 8'(AUTO_GAP - 1)));
    assign clear_d     = rst_i | abort_i | (state_q > EXIT);

`ifdef EMBLEM_BOUNCE_EN
    logic [7:0] x_off_q;
    logic [7:0] x_step_d;
    logic       dir_up_q;

    assign x_step_d = dir_up_q ? (x_off_q + 8'd1) : (x_off_q - 8'd1);
    assign x_off_o  = x_off_q;
`else
    assign x_off_o  = 8'h00;
`endif

    // Sequencer state and all registered outputs; abort and illegal encodings share the reset path.
    always_ff @(posedge clk_i) begin
        if (clear_d) begin
            state_q     <= IDLE;
            emblem_en_q <= 1'b0;
            y_off_q     <= 10'(SLIDE_DIST);
            invert_q    <= 1'b0;
            busy_q      <= 1'b0;
            cnt_q       <= 8'd0;
            gap_q       <= 8'd0;
            pending_q   <= 1'b0;
`ifdef EMBLEM_BOUNCE_EN
            x_off_q     <= 8'd0;
            dir_up_q    <= 1'b1;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (frame_start_i) begin
                        if (start_d) begin
                            state_q     <= ENTER;
                            emblem_en_q <= 1'b1;
                            busy_q      <= 1'b1;
                            y_off_q     <= 10'(SLIDE_DIST);
                            pending_q   <= 1'b0;
                            gap_q       <= 8'd0;
                        end else if (auto_mode_i) begin
                            gap_q <= gap_q + 8'd1;
                        end else begin
                            gap_q <= 8'd0;
                        end
                    end else if (trigger_i) begin
                        pending_q <= 1'b1;
                    end
                end
                ENTER: begin
                    if (frame_start_i) begin
                        y_off_q <= y_dn_d;
                        if (y_dn_d == 10'd0) begin
                            state_q <= HOLD;
                            cnt_q   <= 8'd0;
`ifdef EMBLEM_BOUNCE_EN
                            x_off_q  <= 8'd0;
                            dir_up_q <= 1'b1;
`endif
                        end
                    end
                end
                HOLD: begin
                    if (frame_start_i) begin
                        if (cnt_q == 8'(HOLD_FRAMES - 1)) begin
                            state_q  <= BLINK;
                            cnt_q    <= 8'd0;
                            invert_q <= 1'b1;
                        end else begin
                            cnt_q <= cnt_inc_d;
                        end
`ifdef EMBLEM_BOUNCE_EN
                        // Reverse on touching either limit so the next frame heads back.
                        x_off_q <= x_step_d;
                        if (x_step_d == 8'(BOUNCE_MAX)) begin
                            dir_up_q <= 1'b0;
                        end else if (x_step_d == 8'(-BOUNCE_MAX)) begin
                            dir_up_q <= 1'b1;
                        end
`endif
                    end
                end
                BLINK: begin
                    if (frame_start_i) begin
                        if (cnt_q == 8'(BLINK_FRAMES - 1)) begin
                            state_q  <= EXIT;
                            cnt_q    <= 8'd0;
                            invert_q <= 1'b0;
`ifdef EMBLEM_BOUNCE_EN
                            x_off_q  <= 8'd0;
`endif
                        end else begin
                            cnt_q <= cnt_inc_d;
                            if (blink_tgl_d) begin
                                invert_q <= ~invert_q;
                            end
                        end
                    end
                end
                EXIT: begin
                    if (frame_start_i) begin
                        y_off_q <= y_up_d;
                        if (y_up_d == 10'(SLIDE_DIST)) begin
                            state_q     <= IDLE;
                            emblem_en_q <= 1'b0;
                            busy_q      <= 1'b0;
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign emblem_en_o = emblem_en_q;
    assign y_off_o     = y_off_q;
    assign invert_o    = invert_q;
    assign busy_o      = busy_q;
    assign state_o     = state_q;

endmodule

// File: tb/tb_emblem_sequencer.sv
// Directed self-checking bench for emblem_sequencer: inputs driven and outputs sampled on the falling edge.
module tb_emblem_sequencer;

    logic       clk = 1'b0;
    logic       rst_i, frame_start_i, trigger_i, abort_i, auto_mode_i;
    logic       emblem_en_o, invert_o, busy_o;
    logic [9:0] y_off_o;
    logic [7:0] x_off_o;
    logic [2:0] state_o;

    int checks = 0;
    int errors = 0;
    int xm = 0;
    bit xup = 1'b1;

    always #5 clk = ~clk;

    emblem_sequencer dut (
        .clk_i(clk), .rst_i(rst_i), .frame_start_i(frame_start_i), .trigger_i(trigger_i),
        .abort_i(abort_i), .auto_mode_i(auto_mode_i), .emblem_en_o(emblem_en_o),
        .y_off_o(y_off_o), .x_off_o(x_off_o), .invert_o(invert_o), .busy_o(busy_o),
        .state_o(state_o)
    );

    task automatic frame();
        frame_start_i = 1'b1;
        @(negedge clk);
        frame_start_i = 1'b0;
    endtask

    task automatic pulse_trigger();
        trigger_i = 1'b1;
        @(negedge clk);
        trigger_i = 1'b0;
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        repeat (2) @(negedge clk);
        rst_i = 1'b0;
        checks++;
        if (state_o !== 3'd0 || emblem_en_o !== 1'b0 || busy_o !== 1'b0 || invert_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags: state=%0d en=%b busy=%b inv=%b, want 0/0/0/0", state_o, emblem_en_o, busy_o, invert_o);
        end
        checks++;
        if (y_off_o !== 10'd160 || x_off_o !== 8'd0) begin
            errors++;
            $display("FAIL reset_offsets: y=%0d x=%0d, want 160/0", y_off_o, x_off_o);
        end
    endtask

    task automatic test_full_sequence();
        logic [7:0] xexp;
        logic       inv;
        pulse_trigger();
        checks++;
        if (state_o !== 3'd0) begin
            errors++;
            $display("FAIL pending_no_frame: state=%0d, want 0", state_o);
        end
        frame();
        checks++;
        if (state_o !== 3'd1 || y_off_o !== 10'd160 || emblem_en_o !== 1'b1 || busy_o !== 1'b1) begin
            errors++;
            $display("FAIL enter_entry: state=%0d y=%0d en=%b busy=%b, want 1/160/1/1", state_o, y_off_o, emblem_en_o, busy_o);
        end
        for (int k = 1; k <= 40; k++) begin
            frame();
            checks++;
            if (y_off_o !== 10'(160 - 4 * k) || state_o !== ((k == 40) ? 3'd2 : 3'd1)) begin
                errors++;
                $display("FAIL enter_slide k=%0d: y=%0d state=%0d, want %0d/%0d", k, y_off_o, state_o, 160 - 4 * k, (k == 40) ? 2 : 1);
            end
        end
        xm = 0;
        xup = 1'b1;
        for (int k = 1; k <= 120; k++) begin
            if (k == 60) pulse_trigger();
            frame();
`ifdef EMBLEM_BOUNCE_EN
            xm = xup ? xm + 1 : xm - 1;
            if (xm == 16) xup = 1'b0;
            if (xm == -16) xup = 1'b1;
`endif
            xexp = 8'(xm);
            checks++;
            if (state_o !== ((k == 120) ? 3'd3 : 3'd2) || invert_o !== (k == 120) || y_off_o !== 10'd0 || x_off_o !== xexp) begin
                errors++;
                $display("FAIL hold k=%0d: state=%0d inv=%b y=%0d x=%0d, want %0d/%0d/0/%0d",
                         k, state_o, invert_o, y_off_o, x_off_o, (k == 120) ? 3 : 2, (k == 120) ? 1 : 0, xexp);
            end
        end
        inv = 1'b1;
        for (int k = 1; k <= 32; k++) begin
            frame();
            if (k == 32) begin
                inv = 1'b0;
                xm = 0;
            end else if (k % 8 == 0) begin
                inv = ~inv;
            end
            xexp = 8'(xm);
            checks++;
            if (state_o !== ((k == 32) ? 3'd4 : 3'd3) || invert_o !== inv || x_off_o !== xexp) begin
                errors++;
                $display("FAIL blink k=%0d: state=%0d inv=%b x=%0d, want %0d/%b/%0d",
                         k, state_o, invert_o, x_off_o, (k == 32) ? 4 : 3, inv, xexp);
            end
        end
        for (int k = 1; k <= 40; k++) begin
            frame();
            checks++;
            if (y_off_o !== 10'(4 * k) || state_o !== ((k == 40) ? 3'd0 : 3'd4) ||
                emblem_en_o !== (k != 40) || busy_o !== (k != 40)) begin
                errors++;
                $display("FAIL exit k=%0d: y=%0d state=%0d en=%b busy=%b, want %0d/%0d/%b/%b",
                         k, y_off_o, state_o, emblem_en_o, busy_o, 4 * k, (k == 40) ? 0 : 4, k != 40, k != 40);
            end
        end
    endtask

    task automatic test_no_queue();
        for (int k = 1; k <= 5; k++) begin
            frame();
            checks++;
            if (state_o !== 3'd0 || emblem_en_o !== 1'b0) begin
                errors++;
                $display("FAIL no_queue k=%0d: state=%0d en=%b, want 0/0", k, state_o, emblem_en_o);
            end
        end
    endtask

    task automatic test_same_cycle();
        trigger_i = 1'b1;
        frame();
        trigger_i = 1'b0;
        checks++;
        if (state_o !== 3'd1 || y_off_o !== 10'd160 || emblem_en_o !== 1'b1) begin
            errors++;
            $display("FAIL same_cycle: state=%0d y=%0d en=%b, want 1/160/1", state_o, y_off_o, emblem_en_o);
        end
    endtask

    task automatic test_abort();
        repeat (15) frame();
        checks++;
        if (y_off_o !== 10'd100 || state_o !== 3'd1) begin
            errors++;
            $display("FAIL abort_setup: y=%0d state=%0d, want 100/1", y_off_o, state_o);
        end
        abort_i = 1'b1;
        trigger_i = 1'b1;
        @(negedge clk);
        abort_i = 1'b0;
        trigger_i = 1'b0;
        checks++;
        if (state_o !== 3'd0 || y_off_o !== 10'd160 || emblem_en_o !== 1'b0 || busy_o !== 1'b0 || invert_o !== 1'b0) begin
            errors++;
            $display("FAIL abort_enter: state=%0d y=%0d en=%b busy=%b inv=%b, want 0/160/0/0/0",
                     state_o, y_off_o, emblem_en_o, busy_o, invert_o);
        end
        abort_i = 1'b1;
        trigger_i = 1'b1;
        @(negedge clk);
        abort_i = 1'b0;
        trigger_i = 1'b0;
        frame();
        checks++;
        if (state_o !== 3'd0) begin
            errors++;
            $display("FAIL abort_beats_trigger: state=%0d, want 0", state_o);
        end
    endtask

    task automatic test_auto();
        auto_mode_i = 1'b1;
        for (int k = 1; k <= 60; k++) begin
            frame();
            checks++;
            if (state_o !== ((k == 60) ? 3'd1 : 3'd0)) begin
                errors++;
                $display("FAIL auto_gap k=%0d: state=%0d, want %0d", k, state_o, (k == 60) ? 1 : 0);
            end
        end
        checks++;
        if (y_off_o !== 10'd160 || emblem_en_o !== 1'b1) begin
            errors++;
            $display("FAIL auto_entry: y=%0d en=%b, want 160/1", y_off_o, emblem_en_o);
        end
        auto_mode_i = 1'b0;
        abort_i = 1'b1;
        @(negedge clk);
        abort_i = 1'b0;
        checks++;
        if (state_o !== 3'd0) begin
            errors++;
            $display("FAIL auto_abort: state=%0d, want 0", state_o);
        end
    endtask

    initial begin
        rst_i = 1'b1;
        frame_start_i = 1'b0;
        trigger_i = 1'b0;
        abort_i = 1'b0;
        auto_mode_i = 1'b0;
        @(negedge clk);
        test_reset();
        test_full_sequence();
        test_no_queue();
        test_same_cycle();
        test_abort();
        test_auto();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
